// File: rtl/dac_pkg.sv
// Shared types and the output number-format helper for the DAC DDR framer.
package dac_pkg;

  typedef enum logic [1:0] {
    STREAM = 2'b00,
    ZERO   = 2'b01,
    RAMP   = 2'b10,
    CONST  = 2'b11
  } dac_mode_e;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    PRIME     = 2'b01,
    RUN       = 2'b10,
    UNDERFLOW = 2'b11
  } dac_state_e;

  localparam int unsigned FMT_W = 64;

  // Offset-binary is two's complement with the sample MSB inverted.
  function automatic logic [FMT_W-1:0] fmt_sample(input logic [FMT_W-1:0] value,
                                                  input int unsigned      width,
                                                  input logic             offset_binary);
    return value ^ (FMT_W'(offset_binary) << (width - 1));
  endfunction

endpackage

// File: rtl/dac_sample_fifo.sv
// Synchronous sample FIFO with registered occupancy and registered not-full.
module dac_sample_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     not_full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] level_d;
  logic             not_full_q;

  always_comb level_d = level_q + LVL_W'(push) - LVL_W'(pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      not_full_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q    <= level_d;
      not_full_q <= (level_d != LVL_W'(DEPTH));
    end
  end

  assign rdata    = mem[rd_ptr_q];
  assign level    = level_q;
  assign not_full = not_full_q;

endmodule

// File: rtl/dac_ddr_framer.sv
// AXI-Stream to DDR rise/fall lane framer with priming, test patterns and output format.
module dac_ddr_framer
  import dac_pkg::*;
#(
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned FRAME_LEN     = 4,
  parameter int unsigned PRIME_LEVEL   = 8,
  parameter bit          OFFSET_BINARY = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_axis_valid,
  output logic                          s_axis_ready,
  input  logic [NUM_CH*DATA_W-1:0]      s_axis_data,
  input  logic                          s_axis_last,
  input  logic                          cfg_enable,
  input  logic [1:0]                    cfg_mode,
  input  logic [DATA_W-1:0]             cfg_const,
  output logic [DATA_W-1:0]             oddr_d_rise,
  output logic [DATA_W-1:0]             oddr_d_fall,
  output logic                          oddr_frame_rise,
  output logic                          oddr_frame_fall,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          status_running,
  output logic                          status_underflow
);

  localparam int unsigned LANES  = NUM_CH / 2;
  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned FRM_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned WORD_W = NUM_CH * DATA_W;
  localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DATA_W-1:0] IDLE_VAL = DATA_W'(fmt_sample('0, DATA_W, OFFSET_BINARY));

  dac_state_e          state_q, state_d;
  dac_mode_e           mode_q, cur_mode;
  logic [LANE_W-1:0]   lane_q;
  logic [FRM_W-1:0]    frame_q;
  logic [DATA_W-1:0]   ramp_q;
  logic [LVL_W-1:0]    last_cnt_q;
  logic [LVL_W-1:0]    level;
  logic [WORD_W:0]     head;
  logic [WORD_W-1:0]   head_data;
  logic                head_last;
  logic                push, pop, emit, set_uf;
  logic [DATA_W-1:0]   rise_raw, fall_raw;
  logic [DATA_W-1:0]   d_rise_q, d_fall_q;
  logic                frame_rise_q, frame_fall_q, running_q, underflow_q;

  assign push      = s_axis_valid && s_axis_ready;
  assign head_data = head[WORD_W-1:0];
  assign head_last = head[WORD_W];

  dac_sample_fifo #(
    .WIDTH (WORD_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .wdata    ({s_axis_last, s_axis_data}),
    .rdata    (head),
    .level    (level),
    .not_full (s_axis_ready)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, lane selection and FIFO pop; mode changes only land on lane 0.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    emit     = 1'b0;
    set_uf   = 1'b0;
    rise_raw = '0;
    fall_raw = '0;
    cur_mode = (lane_q == '0) ? dac_mode_e'(cfg_mode) : mode_q;
    unique case (state_q)
      IDLE:  state_d = PRIME;
      PRIME: begin
        if (cur_mode != STREAM || level >= LVL_W'(PRIME_LEVEL) || last_cnt_q != '0)
          state_d = RUN;
      end
      RUN: begin
        unique case (cur_mode)
          STREAM: begin
            if (level == '0) begin
              state_d = UNDERFLOW;
              set_uf  = 1'b1;
            end else begin
              emit     = 1'b1;
              rise_raw = head_data[(2 * int'(lane_q)) * DATA_W +: DATA_W];
              fall_raw = head_data[(2 * int'(lane_q) + 1) * DATA_W +: DATA_W];
              if (lane_q == LANE_W'(LANES - 1)) begin
                pop = 1'b1;
                if (head_last && level == LVL_W'(1) && !push) state_d = PRIME;
              end
            end
          end
          ZERO: emit = 1'b1;
          RAMP: begin
            emit     = 1'b1;
            rise_raw = ramp_q;
            fall_raw = ramp_q + DATA_W'(1);
          end
          CONST: begin
            emit     = 1'b1;
            rise_raw = cfg_const;
            fall_raw = cfg_const;
          end
          default: ;
        endcase
      end
      UNDERFLOW: state_d = PRIME;
      default:   state_d = IDLE;
    endcase
    if (!cfg_enable) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q       <= STREAM;
      lane_q       <= '0;
      frame_q      <= '0;
      ramp_q       <= '0;
      last_cnt_q   <= '0;
      d_rise_q     <= IDLE_VAL;
      d_fall_q     <= IDLE_VAL;
      frame_rise_q <= 1'b0;
      frame_fall_q <= 1'b0;
      running_q    <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      mode_q <= cur_mode;
      // Lane, frame and ramp counters restart every time RUN is entered.
      if (state_q == RUN) begin
        lane_q  <= (lane_q == LANE_W'(LANES - 1)) ? '0 : lane_q + LANE_W'(1);
        frame_q <= (frame_q == FRM_W'(FRAME_LEN - 1)) ? '0 : frame_q + FRM_W'(1);
        ramp_q  <= ramp_q + DATA_W'(2);
      end else begin
        lane_q  <= '0;
        frame_q <= '0;
        ramp_q  <= '0;
      end
      last_cnt_q   <= last_cnt_q + LVL_W'(push && s_axis_last) - LVL_W'(pop && head_last);
      d_rise_q     <= DATA_W'(fmt_sample(FMT_W'(rise_raw), DATA_W, OFFSET_BINARY));
      d_fall_q     <= DATA_W'(fmt_sample(FMT_W'(fall_raw), DATA_W, OFFSET_BINARY));
      frame_rise_q <= emit && (frame_q == '0);
      frame_fall_q <= 1'b0;
      running_q    <= (state_d == RUN);
      if (!cfg_enable)  underflow_q <= 1'b0;
      else if (set_uf)  underflow_q <= 1'b1;
    end
  end

  assign oddr_d_rise      = d_rise_q;
  assign oddr_d_fall      = d_fall_q;
  assign oddr_frame_rise  = frame_rise_q;
  assign oddr_frame_fall  = frame_fall_q;
  assign fifo_level       = level;
  assign status_running   = running_q;
  assign status_underflow = underflow_q;

endmodule

// File: tb/tb_dac_ddr_framer.sv
// Directed bench: default instance (2 ch, two's complement) and a 4 ch offset-binary instance.
module tb_dac_ddr_framer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        v0, last0, en0, rdy0, fr0, ff0, run0, uf0;
  logic [1:0]  mode0;
  logic [15:0] const0, r0, f0;
  logic [31:0] d0;
  logic [4:0]  lvl0;

  logic        v1, last1, en1, rdy1, fr1, ff1, run1, uf1;
  logic [1:0]  mode1;
  logic [15:0] const1, r1, f1;
  logic [63:0] d1;
  logic [2:0]  lvl1;

  int n_checks = 0;
  int n_fail   = 0;

  dac_ddr_framer u_dut0 (
    .clk (clk), .rst (rst),
    .s_axis_valid (v0), .s_axis_ready (rdy0), .s_axis_data (d0), .s_axis_last (last0),
    .cfg_enable (en0), .cfg_mode (mode0), .cfg_const (const0),
    .oddr_d_rise (r0), .oddr_d_fall (f0), .oddr_frame_rise (fr0), .oddr_frame_fall (ff0),
    .fifo_level (lvl0), .status_running (run0), .status_underflow (uf0)
  );

  dac_ddr_framer #(
    .DATA_W (16), .NUM_CH (4), .FIFO_DEPTH (4), .FRAME_LEN (1),
    .PRIME_LEVEL (2), .OFFSET_BINARY (1'b1)
  ) u_dut1 (
    .clk (clk), .rst (rst),
    .s_axis_valid (v1), .s_axis_ready (rdy1), .s_axis_data (d1), .s_axis_last (last1),
    .cfg_enable (en1), .cfg_mode (mode1), .cfg_const (const1),
    .oddr_d_rise (r1), .oddr_d_fall (f1), .oddr_frame_rise (fr1), .oddr_frame_fall (ff1),
    .fifo_level (lvl1), .status_running (run1), .status_underflow (uf1)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] wr(input int i);
    return 16'(16'h1000 + 2 * i);
  endfunction

  function automatic logic [15:0] wf(input int i);
    return 16'(16'h1000 + 2 * i + 1);
  endfunction

  task automatic push0(input int i, input logic last);
    v0 = 1'b1; d0 = {wf(i), wr(i)}; last0 = last;
    tick();
    v0 = 1'b0; last0 = 1'b0;
  endtask

  task automatic push1(input logic [63:0] word);
    v1 = 1'b1; d1 = word;
    tick();
    v1 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    v0 = 0; last0 = 0; d0 = '0; en0 = 0; mode0 = 2'b00; const0 = '0;
    v1 = 0; last1 = 0; d1 = '0; en1 = 0; mode1 = 2'b00; const1 = '0;
    repeat (2) tick();
    check_eq("rst_rise0", r0, 16'h0000);
    check_eq("rst_frame0", fr0, 1'b0);
    check_eq("rst_ready0", rdy0, 1'b0);
    check_eq("rst_level0", lvl0, 0);
    check_eq("rst_uf0", uf0, 1'b0);
    check_eq("rst_rise1", r1, 16'h8000);
    check_eq("rst_fall1", f1, 16'h8000);
    rst = 1'b0;
    tick();
    check_eq("ready0_after_rst", rdy0, 1'b1);

    // Four-channel lane order, offset binary, FRAME_LEN=1.
    en1 = 1'b1;
    push1({16'd4, 16'd3, 16'd2, 16'd1});
    push1({16'd8, 16'd7, 16'd6, 16'd5});
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("ch4_rise", r1, 16'h8001 + 16'(2 * k));
      check_eq("ch4_fall", f1, 16'h8002 + 16'(2 * k));
      check_eq("ch4_level", lvl1, 3'(2 - (k + 1) / 2));
      check_eq("ch4_frame1", fr1, 1'b1);
    end
    tick();
    check_eq("ch4_underflow", uf1, 1'b1);
    check_eq("ch4_uf_idle", r1, 16'h8000);
    en1 = 1'b0;
    repeat (2) tick();
    check_eq("ch4_uf_cleared", uf1, 1'b0);

    // Ramp with offset binary, including counter wrap.
    mode1 = 2'b10; en1 = 1'b1;
    repeat (3) tick();
    check_eq("ramp_r0", r1, 16'h8000);
    check_eq("ramp_f0", f1, 16'h8001);
    tick();
    check_eq("ramp_r1", r1, 16'h8002);
    check_eq("ramp_f1", f1, 16'h8003);
    repeat (32766) tick();
    check_eq("ramp_wrap_r", r1, 16'h7FFE);
    check_eq("ramp_wrap_f", f1, 16'h7FFF);
    tick();
    check_eq("ramp_after_wrap_r", r1, 16'h8000);
    check_eq("ramp_after_wrap_f", f1, 16'h8001);
    mode1 = 2'b11; const1 = 16'h1234;
    repeat (3) tick();
    check_eq("const_rise1", r1, 16'h9234);
    check_eq("const_fall1", f1, 16'h9234);
    en1 = 1'b0;

    // Short burst terminated by last: primes below PRIME_LEVEL.
    en0 = 1'b1;
    for (int i = 0; i < 3; i++) push0(100 + i, 1'b0);
    repeat (4) tick();
    check_eq("prime_hold_run", run0, 1'b0);
    check_eq("prime_hold_rise", r0, 16'h0000);
    check_eq("prime_hold_level", lvl0, 3);
    push0(103, 1'b1);
    tick();
    check_eq("last_run", run0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("last_rise", r0, wr(100 + k));
      check_eq("last_fall", f0, wf(100 + k));
    end
    check_eq("last_back_to_prime", run0, 1'b0);
    tick();
    check_eq("last_idle_rise", r0, 16'h0000);
    check_eq("last_no_uf", uf0, 1'b0);
    check_eq("last_level", lvl0, 0);

    // Ten words then stall: underflow, sticky flag, re-prime.
    for (int i = 0; i < 10; i++) push0(i, 1'b0);
    check_eq("run10_running", run0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      check_eq("run10_rise", r0, wr(k));
      check_eq("run10_fall", f0, wf(k));
      check_eq("run10_frame", fr0, (k % 4) == 0);
      check_eq("run10_level", lvl0, 5'(9 - k));
      check_eq("run10_frame_fall", ff0, 1'b0);
      tick();
    end
    check_eq("uf_rise", r0, 16'h0000);
    check_eq("uf_flag", uf0, 1'b1);
    check_eq("uf_running", run0, 1'b0);
    check_eq("uf_frame", fr0, 1'b0);
    repeat (18) tick();
    check_eq("uf_sticky", uf0, 1'b1);
    check_eq("uf_still_prime", run0, 1'b0);
    for (int i = 0; i < 8; i++) push0(10 + i, 1'b0);
    tick();
    check_eq("reprime_run", run0, 1'b1);
    tick();
    check_eq("reprime_rise", r0, wr(10));
    check_eq("reprime_uf_sticky", uf0, 1'b1);
    en0 = 1'b0;
    tick();
    check_eq("disable_uf_clear", uf0, 1'b0);
    check_eq("disable_running", run0, 1'b0);
    tick();
    check_eq("disable_rise", r0, 16'h0000);

    // Constant mode with a full FIFO, then asynchronous reset mid-run.
    mode0 = 2'b11; const0 = 16'h00AB; en0 = 1'b1;
    for (int i = 0; i < 40 && rdy0; i++) push0(200 + i, 1'b0);
    check_eq("full_level", lvl0, 16);
    check_eq("full_ready", rdy0, 1'b0);
    repeat (2) tick();
    check_eq("const_rise0", r0, 16'h00AB);
    check_eq("const_fall0", f0, 16'h00AB);
    check_eq("const_running", run0, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_rise", r0, 16'h0000);
    check_eq("arst_fall", f0, 16'h0000);
    check_eq("arst_frame", fr0, 1'b0);
    check_eq("arst_level", lvl0, 0);
    check_eq("arst_running", run0, 1'b0);
    tick();
    rst = 1'b0; mode0 = 2'b00;
    tick();
    check_eq("arst_ready_back", rdy0, 1'b1);
    for (int i = 0; i < 7; i++) push0(300 + i, 1'b0);
    repeat (3) tick();
    check_eq("restart_prime", run0, 1'b0);
    check_eq("restart_level", lvl0, 7);
    push0(307, 1'b0);
    tick();
    check_eq("restart_run", run0, 1'b1);
    tick();
    check_eq("restart_rise", r0, wr(300));
    check_eq("restart_fall", f0, wf(300));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
